yarp_lsu: RTL

Parametrised load/store unit between the YARP execute stage and the data-memory bus. It replaces the single-cycle, always-ready data port with a req/gnt/rvalid handshake that tolerates wait states. It adds XLEN=64 doubleword support, misalignment detection, byte-lane steering, sign/zero extension and a response timeout. One access is outstanding at a time.

---
 rtl/yarp_pkg.sv | 40 ++++
 rtl/yarp_lsu_if.sv | 42 ++++
 rtl/yarp_lsu_lane.sv | 55 +++++
 rtl/yarp_lsu.sv | 125 ++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// Shared YARP types: access sizes, LSU error causes, LSU FSM states and alignment helper.
// Pure declarations; no logic, no latency.
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    DWORD     = 2'b10,
    WORD      = 2'b11
  } mem_access_size_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MISALIGN = 2'd1,
    BUS      = 2'd2,
    TIMEOUT  = 2'd3
  } lsu_err_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    ERR
  } lsu_state_t;

  // DWORD is only legal on a 64-bit datapath, otherwise it is reported as misaligned.
  function automatic logic lsu_misaligned(input int xlen, input mem_access_size_t size,
                                          input logic [2:0] addr_lo);
    logic mis;
    mis = 1'b0;
    unique case (size)
      BYTE:      mis = 1'b0;
      HALF_WORD: mis = addr_lo[0];
      WORD:      mis = |addr_lo[1:0];
      DWORD:     mis = (xlen != 64) || (|addr_lo);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/yarp_lsu_if.sv
// Execute-stage request/response and data-memory bus signals of the LSU.
// master = the LSU itself, slave = core plus memory environment.
interface yarp_lsu_if
  import yarp_pkg::*;
#(
  parameter int XLEN = 32
);
  logic              ex_valid_i;
  logic              ex_ready_o;
  logic              ex_wr_i;
  logic [1:0]        ex_size_i;
  logic              ex_zero_extnd_i;
  logic [XLEN-1:0]   ex_addr_i;
  logic [XLEN-1:0]   ex_wdata_i;
  logic              rsp_valid_o;
  logic [XLEN-1:0]   rsp_rdata_o;
  logic              rsp_err_o;
  lsu_err_t          rsp_cause_o;
  logic              mem_req_o;
  logic              mem_gnt_i;
  logic              mem_we_o;
  logic [XLEN-1:0]   mem_addr_o;
  logic [XLEN/8-1:0] mem_be_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_rvalid_i;
  logic [XLEN-1:0]   mem_rdata_i;
  logic              mem_err_i;

  modport master (
    input  ex_valid_i, ex_wr_i, ex_size_i, ex_zero_extnd_i, ex_addr_i, ex_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    output ex_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_cause_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );

  modport slave (
    output ex_valid_i, ex_wr_i, ex_size_i, ex_zero_extnd_i, ex_addr_i, ex_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    input  ex_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_cause_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );
endinterface

// File: rtl/yarp_lsu_lane.sv
// Byte-lane steering: byte enables, store replication, load extract and sign/zero extension.
// Purely combinational, no backpressure.
module yarp_lsu_lane
  import yarp_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int LW   = $clog2(NB)
) (
  input  logic [LW-1:0]     lane,
  input  mem_access_size_t  size,
  input  logic              zero_extnd,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [NB-1:0]     be,
  output logic [XLEN-1:0]   wdata_rep,
  output logic [XLEN-1:0]   rdata_ext
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {lane, 3'b000};

  always_comb begin
    be        = '1;
    wdata_rep = wdata;
    rdata_ext = shifted;
    unique case (size)
      BYTE: begin
        be        = NB'(1) << lane;
        wdata_rep = {NB{wdata[7:0]}};
        if (zero_extnd) rdata_ext = XLEN'(shifted[7:0]);
        else            rdata_ext = XLEN'($signed(shifted[7:0]));
      end
      HALF_WORD: begin
        be        = NB'(3) << lane;
        wdata_rep = {(NB/2){wdata[15:0]}};
        if (zero_extnd) rdata_ext = XLEN'(shifted[15:0]);
        else            rdata_ext = XLEN'($signed(shifted[15:0]));
      end
      WORD: begin
        be        = NB'(15) << lane;
        wdata_rep = {(NB/4){wdata[31:0]}};
        if (zero_extnd) rdata_ext = XLEN'(shifted[31:0]);
        else            rdata_ext = XLEN'($signed(shifted[31:0]));
      end
      DWORD: begin
        be        = '1;
        wdata_rep = wdata;
        rdata_ext = shifted;
      end
    endcase
  end

endmodule

// File: rtl/yarp_lsu.sv
// Load/store unit: one outstanding req/gnt/rvalid access with alignment check and timeout.
// Min latency accept->rsp 3 cycles (misalign 2); waits on gnt/rvalid, no backpressure on rsp.
module yarp_lsu
  import yarp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  yarp_lsu_if.master bus
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT_CYC + 2);

  lsu_state_t       state_q, state_d;
  logic [CW-1:0]    to_cnt;
  logic [XLEN-1:0]  addr_q, wdata_q;
  mem_access_size_t size_q;
  logic             wr_q, zext_q;
  lsu_err_t         cause_q;
  logic             rsp_valid_q, rsp_err_q;
  logic [XLEN-1:0]  rsp_rdata_q;
  lsu_err_t         rsp_cause_q;
  logic             accept, misaligned, timeout_hit, in_req;
  logic [NB-1:0]    lane_be;
  logic [XLEN-1:0]  lane_wdata, lane_rdata;

  assign misaligned  = lsu_misaligned(XLEN, mem_access_size_t'(bus.ex_size_i), bus.ex_addr_i[2:0]);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (to_cnt == CW'(TIMEOUT_CYC - 1));

  yarp_lsu_lane #(.XLEN(XLEN)) u_lane (
    .lane       (addr_q[LW-1:0]),
    .size       (size_q),
    .zero_extnd (zext_q),
    .wdata      (wdata_q),
    .rdata      (bus.mem_rdata_i),
    .be         (lane_be),
    .wdata_rep  (lane_wdata),
    .rdata_ext  (lane_rdata)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.ex_valid_i) begin
        accept  = 1'b1;
        state_d = misaligned ? ERR : REQ;
      end
      REQ: begin
        if (bus.mem_gnt_i)     state_d = RSP;
        else if (timeout_hit)  state_d = ERR;
      end
      RSP: begin
        if (bus.mem_rvalid_i)  state_d = IDLE;
        else if (timeout_hit)  state_d = ERR;
      end
      ERR: state_d = IDLE;
    endcase
  end

  // Bus outputs come straight from the latched access so they hold steady while waiting for gnt.
  assign in_req          = (state_q == REQ);
  assign bus.ex_ready_o  = (state_q == IDLE);
  assign bus.mem_req_o   = in_req;
  assign bus.mem_we_o    = in_req & wr_q;
  assign bus.mem_be_o    = in_req ? lane_be : '0;
  assign bus.mem_addr_o  = in_req ? {addr_q[XLEN-1:LW], {LW{1'b0}}} : '0;
  assign bus.mem_wdata_o = in_req ? lane_wdata : '0;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_cause_o = rsp_cause_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      to_cnt      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= BYTE;
      wr_q        <= 1'b0;
      zext_q      <= 1'b0;
      cause_q     <= NONE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_cause_q <= NONE;
    end else begin
      state_q <= state_d;
      if ((state_d == state_q) && (state_q == REQ || state_q == RSP)) to_cnt <= to_cnt + 1'b1;
      else                                                            to_cnt <= '0;

      if (accept) begin
        addr_q  <= bus.ex_addr_i;
        wdata_q <= bus.ex_wdata_i;
        size_q  <= mem_access_size_t'(bus.ex_size_i);
        wr_q    <= bus.ex_wr_i;
        zext_q  <= bus.ex_zero_extnd_i;
        cause_q <= misaligned ? MISALIGN : NONE;
      end else if (state_d == ERR) begin
        cause_q <= TIMEOUT;
      end

      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_cause_q <= NONE;
      if (state_q == RSP && bus.mem_rvalid_i) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= bus.mem_err_i;
        rsp_cause_q <= bus.mem_err_i ? BUS : NONE;
        rsp_rdata_q <= (wr_q || bus.mem_err_i) ? '0 : lane_rdata;
      end else if (state_q == ERR) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b1;
        rsp_cause_q <= cause_q;
      end
    end
  end

endmodule
